// File: rtl/rr_op_scheduler.sv
// Round-robin scheduler sharing one registered arithmetic unit among num_ch
// req/ack dataflow channels: fetch operands, compute, deliver, one channel at a time.
module rr_op_scheduler #(
    parameter int                    data_width = 32,
    parameter int                    num_ch     = 4,
    parameter int                    ch_bits    = 2,
    parameter string                 op         = "add",
    parameter logic [data_width-1:0] immediate  = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic [num_ch-1:0]                in_req,
    input  logic [num_ch-1:0]                in_ack,
    input  logic [2*data_width*num_ch-1:0]   din,
    input  logic [num_ch-1:0]                dout_req,
    output logic [num_ch-1:0]                dout_ack,
    output logic [data_width*num_ch-1:0]     dout,
    output logic [num_ch-1:0]                grant,
    output logic                             busy
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, SEND} state_t;

    state_t                          state_q, state_d;
    logic [ch_bits-1:0]              ptr_q, ptr_d;
    logic [ch_bits-1:0]              g_q, g_d;
    logic [data_width-1:0]           a_q, a_d, b_q, b_d, r_q, r_d;
    logic [num_ch-1:0]               in_req_q, in_req_d;
    logic [num_ch-1:0]               dout_ack_q, dout_ack_d;
    logic [data_width*num_ch-1:0]    dout_q, dout_d;

    logic [num_ch-1:0]               eligible;
    logic                            found;
    logic [ch_bits-1:0]              pick;

    function automatic logic [data_width-1:0] alu(input logic [data_width-1:0] a,
                                                  input logic [data_width-1:0] b);
        if (op == "sub")       return a - b;
        else if (op == "mul")  return a * b;
        else if (op == "addi") return a + immediate;
        else                   return a + b;
    endfunction

    // A channel whose ack is on the wire this cycle is not re-granted before its consumer reacts.
    assign eligible = dout_req & ~dout_ack_q;

    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < num_ch; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= num_ch) idx = idx - num_ch;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx[ch_bits-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        g_d        = g_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        in_req_d   = in_req_q;
        dout_ack_d = '0;
        dout_d     = dout_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d            = pick;
                    in_req_d       = '0;
                    in_req_d[pick] = 1'b1;
                    state_d        = FETCH;
                end
            end
            FETCH: begin
                if (in_ack[g_q] && in_req_q[g_q]) begin
                    a_d      = din[2*data_width*int'(g_q) +: data_width];
                    b_d      = din[2*data_width*int'(g_q) + data_width +: data_width];
                    in_req_d = '0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                r_d     = alu(a_q, b_q);
                state_d = SEND;
            end
            SEND: begin
                if (dout_req[g_q]) begin
                    dout_d[data_width*int'(g_q) +: data_width] = r_q;
                    dout_ack_d[g_q] = 1'b1;
                    ptr_d   = (int'(g_q) == num_ch - 1) ? '0 : g_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            g_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            r_q        <= '0;
            in_req_q   <= '0;
            dout_ack_q <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            g_q        <= g_d;
            a_q        <= a_d;
            b_q        <= b_d;
            r_q        <= r_d;
            in_req_q   <= in_req_d;
            dout_ack_q <= dout_ack_d;
            dout_q     <= dout_d;
        end
    end

    always_comb begin
        grant = '0;
        if (state_q != IDLE) grant[g_q] = 1'b1;
    end

    assign busy     = (state_q != IDLE);
    assign in_req   = in_req_q;
    assign dout_ack = dout_ack_q;
    assign dout     = dout_q;

endmodule

// File: tb/tb_rr_op_scheduler.sv
// Directed bench for rr_op_scheduler: one "add" instance for arbitration and
// timing, plus mul/sub/addi instances for wrap-around arithmetic.
module tb_rr_op_scheduler;
    localparam int DW = 32;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [NC-1:0]        in_req, in_ack, dout_req, dout_ack, grant;
    logic                 busy;
    logic [2*DW*NC-1:0]   din;
    logic [DW*NC-1:0]     dout;

    // index 0 = mul, 1 = sub, 2 = addi
    logic [NC-1:0]        x_in_req [3];
    logic [NC-1:0]        x_in_ack [3];
    logic [NC-1:0]        x_dout_req [3];
    logic [NC-1:0]        x_dout_ack [3];
    logic [NC-1:0]        x_grant [3];
    logic                 x_busy [3];
    logic [2*DW*NC-1:0]   x_din [3];
    logic [DW*NC-1:0]     x_dout [3];

    int n_cmp = 0;
    int n_bad = 0;

    rr_op_scheduler #(.data_width(DW), .num_ch(NC), .ch_bits(2), .op("add"), .immediate(32'd0)) u_dut (
        .clk(clk), .rst(rst), .in_req(in_req), .in_ack(in_ack), .din(din),
        .dout_req(dout_req), .dout_ack(dout_ack), .dout(dout), .grant(grant), .busy(busy));

    rr_op_scheduler #(.data_width(DW), .num_ch(NC), .ch_bits(2), .op("mul"), .immediate(32'd0)) u_mul (
        .clk(clk), .rst(rst), .in_req(x_in_req[0]), .in_ack(x_in_ack[0]), .din(x_din[0]),
        .dout_req(x_dout_req[0]), .dout_ack(x_dout_ack[0]), .dout(x_dout[0]), .grant(x_grant[0]), .busy(x_busy[0]));

    rr_op_scheduler #(.data_width(DW), .num_ch(NC), .ch_bits(2), .op("sub"), .immediate(32'd0)) u_sub (
        .clk(clk), .rst(rst), .in_req(x_in_req[1]), .in_ack(x_in_ack[1]), .din(x_din[1]),
        .dout_req(x_dout_req[1]), .dout_ack(x_dout_ack[1]), .dout(x_dout[1]), .grant(x_grant[1]), .busy(x_busy[1]));

    rr_op_scheduler #(.data_width(DW), .num_ch(NC), .ch_bits(2), .op("addi"), .immediate(32'd2)) u_addi (
        .clk(clk), .rst(rst), .in_req(x_in_req[2]), .in_ack(x_in_ack[2]), .din(x_din[2]),
        .dout_req(x_dout_req[2]), .dout_ack(x_dout_ack[2]), .dout(x_dout[2]), .grant(x_grant[2]), .busy(x_busy[2]));

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_ack   = '0;
        dout_req = '0;
        din      = '0;
        for (int i = 0; i < 3; i++) begin
            x_in_ack[i]   = '0;
            x_dout_req[i] = '0;
            x_din[i]      = '0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic set_din(input int g, input logic [DW-1:0] a, input logic [DW-1:0] b);
        din[2*DW*g +: DW]      = a;
        din[2*DW*g + DW +: DW] = b;
    endtask

    function automatic logic [DW-1:0] slot(input int g);
        return dout[DW*g +: DW];
    endfunction

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (in_req !== 4'b0000) begin n_bad++; $display("FAIL reset_in_req: got %b want 0000", in_req); end
        n_cmp++; if (dout_ack !== 4'b0000) begin n_bad++; $display("FAIL reset_dout_ack: got %b want 0000", dout_ack); end
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %h want 0", dout); end
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        apply_reset();
        set_din(0, 32'd5, 32'd7);
        dout_req = 4'b0001;
        step();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL add_grant: got %b want 0001", grant); end
        n_cmp++; if (in_req !== 4'b0001) begin n_bad++; $display("FAIL add_in_req: got %b want 0001", in_req); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL add_busy: got %b want 1", busy); end
        step();
        in_ack = 4'b0001;
        step();
        in_ack = 4'b0000;
        n_cmp++; if (in_req !== 4'b0000) begin n_bad++; $display("FAIL add_req_drop: got %b want 0000", in_req); end
        step();
        n_cmp++; if (dout_ack !== 4'b0000) begin n_bad++; $display("FAIL add_early_ack: got %b want 0000", dout_ack); end
        step();
        n_cmp++; if (dout_ack !== 4'b0001) begin n_bad++; $display("FAIL add_ack: got %b want 0001", dout_ack); end
        n_cmp++; if (slot(0) !== 32'd12) begin n_bad++; $display("FAIL add_result: got %0d want 12", slot(0)); end
        step();
        n_cmp++; if (dout_ack !== 4'b0000) begin n_bad++; $display("FAIL add_ack_width: got %b want 0000", dout_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL add_busy_after: got %b want 0", busy); end
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL add_grant_after: got %b want 0000", grant); end
        dout_req = 4'b0000;
    endtask

    task automatic test_fairness();
        int prev;
        int t;
        int g;
        logic [NC-1:0] eg;
        apply_reset();
        for (int i = 0; i < NC; i++) set_din(i, DW'(i), 32'd10);
        dout_req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            g  = k % NC;
            eg = NC'(1) << g;
            step();
            t = 0;
            while (grant === 4'b0000 && t < 20) begin step(); t++; end
            n_cmp++;
            if (t >= 20) begin
                n_bad++;
                $display("FAIL fair_grant_timeout: got no grant want %b", eg);
                dout_req = '0;
                return;
            end
            if (grant !== eg) begin n_bad++; $display("FAIL fair_grant_%0d: got %b want %b", k, grant, eg); end
            if (k > 0) begin
                n_cmp++;
                if (cyc - prev != 5) begin n_bad++; $display("FAIL fair_period_%0d: got %0d want 5", k, cyc - prev); end
            end
            prev = cyc;
            step();
            in_ack[g] = 1'b1;
            step();
            in_ack = '0;
            step();
            step();
            n_cmp++; if (dout_ack !== eg) begin n_bad++; $display("FAIL fair_ack_%0d: got %b want %b", k, dout_ack, eg); end
            n_cmp++; if (slot(g) !== DW'(g + 10)) begin n_bad++; $display("FAIL fair_result_%0d: got %0d want %0d", k, slot(g), g + 10); end
        end
        dout_req = '0;
        step();
        step();
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_r [3];
        exp_r[0] = 32'h0000_0000;
        exp_r[1] = 32'hFFFF_FFFE;
        exp_r[2] = 32'h0000_0001;
        apply_reset();
        x_din[0][63:0] = {32'h0001_0000, 32'h0001_0000};
        x_din[1][63:0] = {32'd5, 32'd3};
        x_din[2][63:0] = {32'h0000_1234, 32'hFFFF_FFFF};
        for (int i = 0; i < 3; i++) x_dout_req[i] = 4'b0001;
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (x_grant[i] !== 4'b0001) begin n_bad++; $display("FAIL wrap_grant_%0d: got %b want 0001", i, x_grant[i]); end
        end
        step();
        for (int i = 0; i < 3; i++) x_in_ack[i] = 4'b0001;
        step();
        for (int i = 0; i < 3; i++) x_in_ack[i] = 4'b0000;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (x_dout_ack[i] !== 4'b0001) begin n_bad++; $display("FAIL wrap_ack_%0d: got %b want 0001", i, x_dout_ack[i]); end
            n_cmp++; if (x_dout[i][DW-1:0] !== exp_r[i]) begin n_bad++; $display("FAIL wrap_result_%0d: got %h want %h", i, x_dout[i][DW-1:0], exp_r[i]); end
        end
        for (int i = 0; i < 3; i++) x_dout_req[i] = '0;
        step();
    endtask

    task automatic test_backpressure();
        apply_reset();
        set_din(2, 32'd100, 32'd23);
        dout_req = 4'b0100;
        step();
        n_cmp++; if (grant !== 4'b0100) begin n_bad++; $display("FAIL bp_grant: got %b want 0100", grant); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (in_req !== 4'b0100 || grant !== 4'b0100) begin
                n_bad++; $display("FAIL bp_fetch_hold_%0d: got req %b grant %b want 0100", i, in_req, grant);
            end
        end
        in_ack   = 4'b0100;
        dout_req = 4'b0000;
        step();
        in_ack = 4'b0000;
        n_cmp++; if (in_req !== 4'b0000) begin n_bad++; $display("FAIL bp_req_drop: got %b want 0000", in_req); end
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (dout_ack !== 4'b0000 || grant !== 4'b0100 || busy !== 1'b1) begin
                n_bad++; $display("FAIL bp_send_hold_%0d: got ack %b grant %b busy %b want 0000 0100 1", i, dout_ack, grant, busy);
            end
        end
        dout_req = 4'b0100;
        step();
        n_cmp++; if (dout_ack !== 4'b0100) begin n_bad++; $display("FAIL bp_ack: got %b want 0100", dout_ack); end
        n_cmp++; if (slot(2) !== 32'd123) begin n_bad++; $display("FAIL bp_result: got %0d want 123", slot(2)); end
        dout_req = 4'b0000;
        step();
    endtask

    task automatic test_spurious_ack();
        apply_reset();
        set_din(1, 32'd20, 32'd22);
        set_din(2, 32'h0000_DEAD, 32'h0000_DEAD);
        dout_req = 4'b0010;
        step();
        n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL spur_grant: got %b want 0010", grant); end
        in_ack = 4'b0100;
        step();
        n_cmp++; if (in_req !== 4'b0010 || grant !== 4'b0010) begin n_bad++; $display("FAIL spur_still_fetch: got req %b grant %b want 0010", in_req, grant); end
        in_ack = 4'b0010;
        step();
        in_ack = 4'b0000;
        step();
        n_cmp++; if (dout_ack !== 4'b0000) begin n_bad++; $display("FAIL spur_early_ack: got %b want 0000", dout_ack); end
        step();
        n_cmp++; if (dout_ack !== 4'b0010) begin n_bad++; $display("FAIL spur_ack: got %b want 0010", dout_ack); end
        n_cmp++; if (slot(1) !== 32'd42) begin n_bad++; $display("FAIL spur_result: got %0d want 42", slot(1)); end
        n_cmp++; if (slot(2) !== 32'd0) begin n_bad++; $display("FAIL spur_slot2: got %h want 0", slot(2)); end
        dout_req = 4'b0000;
        in_ack   = 4'b1111;
        step();
        n_cmp++; if (busy !== 1'b0 || in_req !== 4'b0000) begin n_bad++; $display("FAIL spur_idle_ack: got busy %b req %b want 0 0000", busy, in_req); end
        in_ack = 4'b0000;
    endtask

    task automatic test_reset_mid_fetch();
        // Runs right after test_spurious_ack: ptr sits at 2 and dout slot 1 holds 42.
        dout_req = 4'b0010;
        step();
        n_cmp++; if (grant !== 4'b0010 || in_req !== 4'b0010) begin n_bad++; $display("FAIL rmf_grant: got grant %b req %b want 0010", grant, in_req); end
        rst      = 1'b1;
        dout_req = 4'b0000;
        step();
        rst = 1'b0;
        n_cmp++; if (in_req !== 4'b0000) begin n_bad++; $display("FAIL rmf_in_req: got %b want 0000", in_req); end
        n_cmp++; if (grant !== 4'b0000) begin n_bad++; $display("FAIL rmf_grant_clr: got %b want 0000", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmf_busy: got %b want 0", busy); end
        n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL rmf_dout: got %h want 0", dout); end
        in_ack = 4'b0010;
        step();
        in_ack = 4'b0000;
        n_cmp++; if (busy !== 1'b0 || dout_ack !== 4'b0000) begin n_bad++; $display("FAIL rmf_late_ack: got busy %b ack %b want 0 0000", busy, dout_ack); end
        dout_req = 4'b1001;
        step();
        n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL rmf_ptr: got %b want 0001", grant); end
        apply_reset();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_add();
        test_fairness();
        test_wrap();
        test_backpressure();
        test_spurious_ack();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
